// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL clock sequencer: state encodings and
// the counter-width derivation used by the sequencer and its timer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF         = 3'd0,
    ST_PWR_UP      = 3'd1,
    ST_UNGATE_WAIT = 3'd2,
    ST_RUN         = 3'd3,
    ST_GATE_DRAIN  = 3'd4,
    ST_PWR_DOWN    = 3'd5
  } seq_state_e;

  // Wide enough to hold the largest interval, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// Loadable down-counter that times the settle, lock and drain intervals.
// It stops at zero; load has priority over decrement.
module pll_seq_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pll_clock_sequencer.sv
// Always-on sequencer for the PLL clock source: powers it up, ungates it,
// waits for lock, grants acks while requested, then drains and powers down.
module pll_clock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PWR_SETTLE_CYC = 16,
  parameter int LOCK_CYC       = 64,
  parameter int DRAIN_CYC      = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_off,
  output logic [NUM_REQ-1:0] ack,
  output logic               pll_power,
  output logic               pll_gate,
  output logic               clk_running,
  output logic               busy,
  output logic [2:0]         state_o
);

  localparam int CNT_W = cnt_width(PWR_SETTLE_CYC, LOCK_CYC, DRAIN_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);

  seq_state_e        state_q, state_d;
  logic              t_load, t_dec, t_zero;
  logic [CNT_W-1:0]  t_load_val;
  logic [CNT_W-1:0]  t_value;

  pll_seq_timer #(.W(CNT_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .value    (t_value),
    .zero     (t_zero)
  );

  always_comb begin
    state_d    = state_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    case (state_q)
      ST_OFF: begin
        if ((|req) && !force_off) begin
          state_d    = ST_PWR_UP;
          t_load     = 1'b1;
          t_load_val = SETTLE_LD;
        end
      end
      ST_PWR_UP: begin
        if (force_off) begin
          state_d    = ST_GATE_DRAIN;
          t_load     = 1'b1;
          t_load_val = DRAIN_LD;
        end else if (t_zero) begin
          state_d    = ST_UNGATE_WAIT;
          t_load     = 1'b1;
          t_load_val = LOCK_LD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_UNGATE_WAIT: begin
        if (force_off) begin
          state_d    = ST_GATE_DRAIN;
          t_load     = 1'b1;
          t_load_val = DRAIN_LD;
        end else if (t_zero) begin
          state_d = ST_RUN;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (!(|req) || force_off) begin
          state_d    = ST_GATE_DRAIN;
          t_load     = 1'b1;
          t_load_val = DRAIN_LD;
        end
      end
      ST_GATE_DRAIN: begin
        if (t_zero) state_d = ST_PWR_DOWN;
        else        t_dec   = 1'b1;
      end
      ST_PWR_DOWN: state_d = ST_OFF;
      default:     state_d = ST_OFF;
    endcase
  end

  // Outputs are registered from the next state, so they change on the same
  // edge as the state and the gate/power invariants hold by construction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      pll_power   <= 1'b0;
      pll_gate    <= 1'b1;
      ack         <= '0;
      clk_running <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pll_power   <= (state_d inside {ST_PWR_UP, ST_UNGATE_WAIT, ST_RUN, ST_GATE_DRAIN});
      pll_gate    <= !(state_d inside {ST_UNGATE_WAIT, ST_RUN});
      ack         <= (state_d == ST_RUN) ? req : '0;
      clk_running <= (state_d == ST_RUN);
      busy        <= !(state_d inside {ST_OFF, ST_RUN});
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Directed bench for pll_clock_sequencer: a checkpoint table for the start-up
// sequence plus hand-written sequences for drain, force_off, and reset cases.
module tb_pll_clock_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       force_off = 1'b0;
  logic [3:0] ack;
  logic       pll_power, pll_gate, clk_running, busy;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [3:0] exp_q[$];

  pll_clock_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .force_off   (force_off),
    .ack         (ack),
    .pll_power   (pll_power),
    .pll_gate    (pll_gate),
    .clk_running (clk_running),
    .busy        (busy),
    .state_o     (state_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    force_off = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    cyc     = 0;
    mon_en  = 1'b1;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic pwr,
                         input logic gate, input logic [3:0] a, input logic run,
                         input logic bsy);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".power"}, 32'(pll_power), 32'(pwr));
    chk({tag, ".gate"}, 32'(pll_gate), 32'(gate));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".running"}, 32'(clk_running), 32'(run));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  // invariants, sampled away from the active edge
  always @(negedge clock) begin
    if (mon_en) begin
      chk("inv_gate_open_state", 32'(!pll_gate && !(state_o inside {3'd2, 3'd3})), 32'd0);
      chk("inv_power_state", 32'(pll_power && !(state_o inside {3'd1, 3'd2, 3'd3, 3'd4})), 32'd0);
      chk("inv_gate_without_power", 32'(!pll_gate && !pll_power), 32'd0);
      chk("inv_ack_outside_run", 32'((ack != 4'd0) && (state_o != 3'd3)), 32'd0);
    end
  end

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       pwr;
    logic       gate;
    logic [3:0] a;
    logic       run;
    logic       bsy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit saw_ack;
    vecs[0] = '{0,  3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{1,  3'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[2] = '{16, 3'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[3] = '{17, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{80, 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[5] = '{81, 3'd3, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};

    do_reset();
    chk_all("reset", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);

    // 1: start-up checkpoints
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      run_to(vecs[i].cyc);
      chk_all($sformatf("startup[%0d]", vecs[i].cyc), vecs[i].st, vecs[i].pwr,
              vecs[i].gate, vecs[i].a, vecs[i].run, vecs[i].bsy);
    end

    // 2: ack follows req with one-cycle latency, then drain
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
    req = 4'b0011;
    step();
    chk("run.ack_rise", 32'(ack), 32'(exp_q.pop_front()));
    req = 4'b0000;
    step();
    chk("drain.ack", 32'(ack), 32'(exp_q.pop_front()));
    chk_all("drain_entry", 3'd4, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_to(90);
    chk_all("drain_last", 3'd4, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_to(91);
    chk_all("pwr_down", 3'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_to(92);
    chk_all("off_after_drain", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);

    // 3: force_off pulse during lock wait
    do_reset();
    req = 4'b0001;
    run_to(40);
    chk("force.pre_state", 32'(state_o), 32'd2);
    force_off = 1'b1;
    step();
    force_off = 1'b0;
    chk_all("force.drain", 3'd4, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    saw_ack = 1'b0;
    while (cyc < 130) begin
      step();
      if (ack != 4'd0) saw_ack = 1'b1;
      if (cyc == 49) chk_all("force.pwr_down", 3'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
      if (cyc == 50) chk_all("force.off", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
      if (cyc == 51) chk_all("force.restart", 3'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    end
    chk("force.no_early_ack", 32'(saw_ack), 32'd0);
    run_to(131);
    chk_all("force.run_after_restart", 3'd3, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);

    // 4: request lost mid-sequence still reaches RUN, then exits
    do_reset();
    req = 4'b0001;
    run_to(20);
    req = 4'b0000;
    run_to(81);
    chk_all("reqloss.run", 3'd3, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_to(82);
    chk_all("reqloss.drain", 3'd4, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);

    // 5: re-request during drain completes shutdown first
    do_reset();
    req = 4'b0001;
    run_to(81);
    req = 4'b0000;
    run_to(82);
    chk("rereq.drain", 32'(state_o), 32'd4);
    run_to(85);
    req = 4'b0001;
    run_to(90);
    chk_all("rereq.pwr_down", 3'd5, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_to(91);
    chk_all("rereq.off", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_to(92);
    chk_all("rereq.pwr_up", 3'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_to(171);
    chk_all("rereq.lock_last", 3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    run_to(172);
    chk_all("rereq.run", 3'd3, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);

    // 6: reset while running
    do_reset();
    req = 4'b0001;
    run_to(81);
    chk("rst.pre_state", 32'(state_o), 32'd3);
    reset_n = 1'b0;
    step();
    chk_all("rst.in_run", 3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    reset_n = 1'b1;
    req = 4'b0000;
    step();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
